// File: rtl/apb_ram_param.sv
// APB4 slave RAM with byte strobes, programmable wait states, out-of-range error response
// and optional clear-on-reset. Each transfer is latched at setup and executed at the end of ACCESS.
module apb_ram_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 32,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer is accepted only from IDLE on psel=1,penable=0; it completes on the
  // single cycle where pready=1, and prdata/pslverr are meaningful only during that cycle.
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_nxt;
  logic [STRB_W-1:0]     lat_strb, lat_strb_nxt;
  logic                  lat_write, lat_write_nxt;
  logic [DATA_WIDTH-1:0] prdata_nxt;
  logic                  pready_nxt, pslverr_nxt;
  logic                  do_write;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Full-width compare so large addresses never alias onto a valid word.
  assign in_range = ({1'b0, lat_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = lat_addr[IDX_W-1:0];

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_strb_nxt  = lat_strb;
    lat_write_nxt = lat_write;
    prdata_nxt    = '0;
    pready_nxt    = 1'b0;
    pslverr_nxt   = 1'b0;
    do_write      = 1'b0;
    case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          lat_addr_nxt  = paddr;
          lat_wdata_nxt = pwdata;
          lat_strb_nxt  = pstrb;
          lat_write_nxt = pwrite;
          cnt_nxt       = 4'(WAIT_STATES);
          state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_nxt = S_IDLE;
        end else if (penable) begin
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            pready_nxt = 1'b1;
            state_nxt  = S_DONE;
            if (!in_range) begin
              pslverr_nxt = 1'b1;
            end else if (lat_write) begin
              do_write = 1'b1;
            end else begin
              prdata_nxt = mem[idx];
            end
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      lat_write <= 1'b0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_strb  <= lat_strb_nxt;
      lat_write <= lat_write_nxt;
      prdata    <= prdata_nxt;
      pready    <= pready_nxt;
      pslverr   <= pslverr_nxt;
    end
  end

  // Reset takes priority over the commit, so a reset on the execute edge drops the write.
  always_ff @(posedge pclk) begin
    if (preset) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else if (do_write) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (lat_strb[b]) mem[idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_apb_ram_param.sv
// Directed bench for apb_ram_param: a zero-wait clearing instance and a three-wait
// non-clearing instance, driven from a vector table plus abort/reset sequences.
module tb_apb_ram_param;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 pclk = ~pclk;

  apb_ram_param #(.WAIT_STATES(0), .CLEAR_ON_RESET(1)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_ram_param #(.WAIT_STATES(3), .CLEAR_ON_RESET(0)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full APB transfer; returns captured data/error and the number of edges from setup to pready.
  task automatic xfer(input bit use3, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int lat);
    bit seen;
    seen = 1'b0;
    rd   = '0;
    err  = 1'b0;
    lat  = 0;
    @(negedge pclk);
    if (use3) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); lat++;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = addr + 32'd1;
    pwdata  = ~data;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge pclk); lat++;
      @(negedge pclk);
      if (use3 ? pready3 : pready0) begin
        seen = 1'b1;
        rd   = use3 ? prdata3 : prdata0;
        err  = use3 ? pslverr3 : pslverr0;
      end
    end
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    chk("pready_timeout", 32'(seen), 32'd1);
    @(posedge pclk);
    @(negedge pclk);
    chk("pready_one_cycle", 32'(use3 ? pready3 : pready0), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    vecs[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd5,          32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'h11223344, 4'hF,    32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'd7,          32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'd7,          32'h0,        4'hF,    32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'd32,         32'h1,        4'hF,    32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'h0,        4'h0,    32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'd0,          32'h0,        4'h0,    32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'd31,         32'hCAFEF00D, 4'h0,    32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'd31,         32'h0,        4'h0,    32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'd31,         32'hCAFEF00D, 4'b1000, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'd31,         32'h0,        4'h0,    32'hCA000000, 1'b0};
    vecs[12] = '{1'b1, 32'd0,          32'h12345678, 4'hF,    32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'd0,          32'h0,        4'h0,    32'h12345678, 1'b0};

    // Reset held for two edges; outputs idle, then every word reads zero.
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_pready", 32'(pready0), 32'd0);
    chk("reset_pslverr", 32'(pslverr0), 32'd0);
    chk("reset_prdata", prdata0, 32'h0);
    chk("reset_pready_ws3", 32'(pready3), 32'd0);
    preset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      xfer(1'b0, 1'b0, 32'(a), 32'h0, 4'h0, rd, err, lat);
      chk($sformatf("reset_word_%0d", a), rd, 32'h0);
    end

    for (int v = 0; v < 14; v++) begin
      if (!vecs[v].wr) exp_q.push_back(vecs[v].exp_rd);
      xfer(1'b0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, err, lat);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_pslverr", v), 32'(err), 32'(vecs[v].exp_err));
      if (!vecs[v].wr) chk($sformatf("vec%0d_prdata", v), rd, exp_q.pop_front());
    end

    // Wait states: write then read on the three-wait instance.
    xfer(1'b1, 1'b1, 32'd2, 32'h0000_0055, 4'hF, rd, err, lat);
    chk("ws3_write_latency", 32'(lat), 32'd5);
    xfer(1'b1, 1'b0, 32'd2, 32'h0, 4'h0, rd, err, lat);
    chk("ws3_read_latency", 32'(lat), 32'd5);
    chk("ws3_read_data", rd, 32'h0000_0055);
    chk("ws3_read_err", 32'(err), 32'd0);

    // Abort: psel dropped during ACCESS leaves the word untouched.
    xfer(1'b0, 1'b1, 32'd9, 32'h0000_0099, 4'hF, rd, err, lat);
    @(negedge pclk);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd9; pwdata = 32'h1111_1111; pstrb = 4'hF;
    @(posedge pclk);
    @(negedge pclk);
    psel0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk);
      @(negedge pclk);
      chk($sformatf("abort_pready_%0d", c), 32'(pready0), 32'd0);
    end
    xfer(1'b0, 1'b0, 32'd9, 32'h0, 4'h0, rd, err, lat);
    chk("abort_word_kept", rd, 32'h0000_0099);

    // Reset in the middle of a waited write on the non-clearing instance.
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd2; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rst_mid_pready_%0d", c), 32'(pready3), 32'd0);
      @(posedge pclk);
      @(negedge pclk);
    end
    xfer(1'b1, 1'b0, 32'd2, 32'h0, 4'h0, rd, err, lat);
    chk("rst_mid_word_kept", rd, 32'h0000_0055);
    chk("rst_mid_next_latency", 32'(lat), 32'd5);
    xfer(1'b0, 1'b0, 32'd5, 32'h0, 4'h0, rd, err, lat);
    chk("rst_cleared_word", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
